// File: rtl/mtpsa_tuple_bridge.sv
// SUME<->SDNet tuple bridge: input-side SOP tracking for the SDNet tuple VALID/TLAST,
// output-side metadata FIFO that presents one merged tuser per output packet.
module mtpsa_tuple_bridge #(
    parameter int TUPLE_WIDTH          = 128,
    parameter int DIGEST_WIDTH         = 256,
    parameter int TUSER_KEEP_WIDTH     = 48,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int META_DEPTH           = 4,
    parameter int MERGE_MODE           = 1,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic                            sdnet_tuple_in_valid,
    output logic                            sdnet_in_tlast,
    input  logic                            tuple_out_valid,
    input  logic [TUPLE_WIDTH-1:0]          tuple_out_data,
    input  logic [DIGEST_WIDTH-1:0]         digest_out_data,
    input  logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic                            m_axis_tlast,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                            meta_full,
    output logic                            meta_empty,
    output logic [CNT_WIDTH-1:0]            err_underflow_cnt,
    output logic [CNT_WIDTH-1:0]            err_overflow_cnt
);

    localparam int PTR_W = $clog2(META_DEPTH);
    localparam logic [0:0] ST_SOP  = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(META_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [0:0]                      in_state_q, in_state_d;
    logic [0:0]                      out_state_q, out_state_d;
    logic                            uf_pkt_q, uf_pkt_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                  count_q, count_d;
    logic [CNT_WIDTH-1:0]            udf_cnt_q, udf_cnt_d;
    logic [CNT_WIDTH-1:0]            ovf_cnt_q, ovf_cnt_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] mem_q [META_DEPTH];
    logic [C_M_AXIS_TUSER_WIDTH-1:0] entry_s;

    logic s_accept_s, m_accept_s, m_sop_s;
    logic empty_s, full_s, push_s, pop_s, ovf_s, udf_s;
    logic unused_bits_s;

    // Only part of the tuple/digest reaches the FIFO in either merge mode.
    assign unused_bits_s = ^{tuple_out_data, digest_out_data};

    generate
        if (MERGE_MODE == 1) begin : g_merge
            assign entry_s = {digest_out_data, tuple_out_data[TUSER_KEEP_WIDTH-1:0]};
        end else if (TUPLE_WIDTH >= C_M_AXIS_TUSER_WIDTH) begin : g_trunc
            assign entry_s = tuple_out_data[C_M_AXIS_TUSER_WIDTH-1:0];
        end else begin : g_zext
            assign entry_s = {{(C_M_AXIS_TUSER_WIDTH-TUPLE_WIDTH){1'b0}}, tuple_out_data};
        end
    endgenerate

    assign s_accept_s = s_axis_tvalid & s_axis_tready;
    assign m_accept_s = m_axis_tvalid & m_axis_tready;
    assign m_sop_s    = m_accept_s & (out_state_q == ST_SOP);
    assign empty_s    = (count_q == {(PTR_W+1){1'b0}});
    assign full_s     = (count_q == DEPTH_CNT);
    // An underflowed packet never owns a FIFO entry, even one pushed while it is in flight.
    assign pop_s      = m_accept_s & m_axis_tlast & ~empty_s & ~uf_pkt_q;
    assign push_s     = tuple_out_valid & (~full_s | pop_s);
    assign ovf_s      = tuple_out_valid & full_s & ~pop_s;
    assign udf_s      = m_sop_s & empty_s;

    assign sdnet_tuple_in_valid = s_accept_s & (in_state_q == ST_SOP);
    assign sdnet_in_tlast       = s_axis_tvalid & s_axis_tlast;
    assign meta_empty           = empty_s;
    assign meta_full            = full_s;
    assign err_underflow_cnt    = udf_cnt_q;
    assign err_overflow_cnt     = ovf_cnt_q;
    assign m_axis_tuser         = (empty_s | uf_pkt_q) ? {C_M_AXIS_TUSER_WIDTH{1'b0}} : mem_q[rd_ptr_q];

    always_comb begin
        in_state_d = in_state_q;
        if (s_accept_s) begin
            in_state_d = s_axis_tlast ? ST_SOP : ST_BODY;
        end else begin
            in_state_d = in_state_q;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        uf_pkt_d    = uf_pkt_q;
        if (m_accept_s) begin
            out_state_d = m_axis_tlast ? ST_SOP : ST_BODY;
            if (m_axis_tlast) begin
                uf_pkt_d = 1'b0;
            end else if (m_sop_s) begin
                uf_pkt_d = empty_s;
            end else begin
                uf_pkt_d = uf_pkt_q;
            end
        end else begin
            out_state_d = out_state_q;
        end
    end

    always_comb begin
        wr_ptr_d  = push_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d  = pop_s  ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
        udf_cnt_d = (udf_s && udf_cnt_q != CNT_MAX) ? udf_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : udf_cnt_q;
        ovf_cnt_d = (ovf_s && ovf_cnt_q != CNT_MAX) ? ovf_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : ovf_cnt_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            in_state_q  <= ST_SOP;
            out_state_q <= ST_SOP;
            uf_pkt_q    <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {(PTR_W+1){1'b0}};
            udf_cnt_q   <= {CNT_WIDTH{1'b0}};
            ovf_cnt_q   <= {CNT_WIDTH{1'b0}};
            for (int i = 0; i < META_DEPTH; i++) begin
                mem_q[i] <= {C_M_AXIS_TUSER_WIDTH{1'b0}};
            end
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            uf_pkt_q    <= uf_pkt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            udf_cnt_q   <= udf_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
            end
        end
    end

endmodule

// File: tb/tb_mtpsa_tuple_bridge.sv
// Scoreboard bench for mtpsa_tuple_bridge with default parameters (MERGE_MODE=1, depth 4).
module tb_mtpsa_tuple_bridge;

    localparam int TW = 304;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_tvalid, s_tready, s_tlast;
    logic          tiv, in_tlast;
    logic          t_valid;
    logic [127:0]  t_data;
    logic [255:0]  d_data;
    logic          m_tvalid, m_tready, m_tlast;
    logic [TW-1:0] m_tuser;
    logic          full, empty;
    logic [15:0]   udf_cnt, ovf_cnt;

    int checks   = 0;
    int failures = 0;
    logic [1:0]    s_q [$];
    logic [TW-1:0] m_q [$];

    mtpsa_tuple_bridge dut (
        .axis_aclk(clk), .axis_resetn(resetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .sdnet_tuple_in_valid(tiv), .sdnet_in_tlast(in_tlast),
        .tuple_out_valid(t_valid), .tuple_out_data(t_data), .digest_out_data(d_data),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .meta_full(full), .meta_empty(empty),
        .err_underflow_cnt(udf_cnt), .err_overflow_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] merge(input logic [127:0] t, input logic [255:0] d);
        return {d, t[47:0]};
    endfunction

    function automatic logic [127:0] tup(input int i);
        return {96'hFEED_0000_0000_0000_1111_0000, 32'(i)};
    endfunction

    function automatic logic [255:0] dig(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {8{w}};
    endfunction

    // Monitor: compare every accepted beat on either stream against the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            if (s_tvalid && s_tready) begin
                if (s_q.size() == 0) chk("s_unexpected_beat", 304'd1, 304'd0);
                else chk("s_beat_tiv_tlast", {302'd0, tiv, in_tlast}, {302'd0, s_q.pop_front()});
            end
            if (m_tvalid && m_tready) begin
                if (m_q.size() == 0) chk("m_unexpected_beat", 304'd1, 304'd0);
                else chk("m_beat_tuser", m_tuser, m_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0; s_tready = 1'b0; s_tlast = 1'b0;
        m_tvalid = 1'b0; m_tready = 1'b0; m_tlast = 1'b0;
        t_valid  = 1'b0;
    endtask

    task automatic s_beat(input logic last, input logic exp_tiv);
        s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = last;
        s_q.push_back({exp_tiv, last});
        step();
        s_tvalid = 1'b0; s_tready = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic push(input logic [127:0] t, input logic [255:0] d);
        t_valid = 1'b1; t_data = t; d_data = d;
        step();
        t_valid = 1'b0;
    endtask

    // One output beat, optionally with a coincident tuple push.
    task automatic m_beat(input logic last, input logic [TW-1:0] exp, input logic do_push,
                          input logic [127:0] t, input logic [255:0] d);
        m_tvalid = 1'b1; m_tready = 1'b1; m_tlast = last;
        t_valid = do_push; t_data = t; d_data = d;
        m_q.push_back(exp);
        step();
        m_tvalid = 1'b0; m_tready = 1'b0; m_tlast = 1'b0; t_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        logic [127:0]  t0;
        logic [255:0]  d0;
        logic [TW-1:0] e0;
        idle();
        t_data = 128'd0; d_data = 256'd0;
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;

        chk("reset_empty", {303'd0, empty}, 304'd1);
        chk("reset_full", {303'd0, full}, 304'd0);
        chk("reset_tuser", m_tuser, 304'd0);
        chk("reset_tiv", {303'd0, tiv}, 304'd0);
        chk("reset_udf", {288'd0, udf_cnt}, 304'd0);
        chk("reset_ovf", {288'd0, ovf_cnt}, 304'd0);

        // Packets of 1, 4, 2 beats back to back.
        s_beat(1'b1, 1'b1);
        s_beat(1'b0, 1'b1); s_beat(1'b0, 1'b0); s_beat(1'b0, 1'b0); s_beat(1'b1, 1'b0);
        s_beat(1'b0, 1'b1); s_beat(1'b1, 1'b0);

        // Merge of one tuple/digest across a 3-beat output packet.
        t0 = 128'hDEAD_BEEF_0000_0000_0000_0001_0401_0040;
        d0 = {32{8'hAB}};
        e0 = {{32{8'hAB}}, 48'h0001_0401_0040};
        push(t0, d0);
        chk("merge_head", m_tuser, e0);
        m_beat(1'b0, e0, 1'b0, t0, d0);
        m_beat(1'b0, e0, 1'b0, t0, d0);
        m_beat(1'b1, e0, 1'b0, t0, d0);
        chk("merge_after_tuser", m_tuser, 304'd0);
        chk("merge_after_empty", {303'd0, empty}, 304'd1);

        // Five pushes into a depth-4 FIFO, then drain.
        for (int i = 1; i <= 5; i++) begin
            push(tup(i), dig(i));
            if (i == 4) chk("fill_full_after_4", {303'd0, full}, 304'd1);
        end
        chk("fill_ovf_cnt", {288'd0, ovf_cnt}, 304'd1);
        for (int i = 1; i <= 4; i++) begin
            m_beat(1'b0, merge(tup(i), dig(i)), 1'b0, t0, d0);
            m_beat(1'b1, merge(tup(i), dig(i)), 1'b0, t0, d0);
        end
        chk("drain_empty", {303'd0, empty}, 304'd1);

        // Full FIFO with a push coinciding with the EOP pop.
        do_reset();
        for (int i = 11; i <= 14; i++) push(tup(i), dig(i));
        m_beat(1'b0, merge(tup(11), dig(11)), 1'b0, t0, d0);
        m_beat(1'b1, merge(tup(11), dig(11)), 1'b1, tup(15), dig(15));
        chk("pushpop_full", {303'd0, full}, 304'd1);
        chk("pushpop_ovf", {288'd0, ovf_cnt}, 304'd0);
        for (int i = 12; i <= 15; i++) m_beat(1'b1, merge(tup(i), dig(i)), 1'b0, t0, d0);
        chk("pushpop_drained", {303'd0, empty}, 304'd1);

        // Underflow: packet with empty FIFO, tuple arrives mid-packet.
        m_beat(1'b0, 304'd0, 1'b0, t0, d0);
        m_beat(1'b0, 304'd0, 1'b1, tup(21), dig(21));
        m_beat(1'b1, 304'd0, 1'b0, t0, d0);
        chk("udf_cnt", {288'd0, udf_cnt}, 304'd1);
        chk("udf_entry_kept", {303'd0, empty}, 304'd0);
        m_beat(1'b1, merge(tup(21), dig(21)), 1'b0, t0, d0);
        chk("udf_next_empty", {303'd0, empty}, 304'd1);

        // Reset mid-packet with two entries buffered.
        push(tup(31), dig(31));
        push(tup(32), dig(32));
        s_beat(1'b0, 1'b1);
        m_beat(1'b0, merge(tup(31), dig(31)), 1'b0, t0, d0);
        do_reset();
        chk("rst_mid_empty", {303'd0, empty}, 304'd1);
        chk("rst_mid_tuser", m_tuser, 304'd0);
        chk("rst_mid_udf", {288'd0, udf_cnt}, 304'd0);
        chk("rst_mid_ovf", {288'd0, ovf_cnt}, 304'd0);
        s_beat(1'b0, 1'b1);
        s_beat(1'b1, 1'b0);

        step();
        chk("s_queue_drained", 304'(s_q.size()), 304'd0);
        chk("m_queue_drained", 304'(m_q.size()), 304'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
